// File: rtl/vend_pkg.sv
// Shared codes and state encoding for the vending back end.
package vend_pkg;

    localparam int unsigned ITEM_W = 2;
    localparam int unsigned CHG_W  = 2;
    localparam int unsigned REM_W  = 3;

    typedef enum logic [ITEM_W-1:0] {
        NO_ITEM     = 2'd0,
        ITEM_TWENTY = 2'd1,
        ITEM_FIFTY  = 2'd2
    } item_e;

    typedef enum logic [CHG_W-1:0] {
        NO_CHANGE   = 2'd0,
        TEN_BACK    = 2'd1,
        THIRTY_BACK = 2'd2,
        FORTY_BACK  = 2'd3
    } change_e;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_TIMEOUT = 2'd1,
        FAULT_SHORT   = 2'd2
    } fault_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ITEM_REQ = 3'd1,
        ST_ITEM_REL = 3'd2,
        ST_COIN_SEL = 3'd3,
        ST_COIN_REQ = 3'd4,
        ST_COIN_REL = 3'd5,
        ST_FAULT    = 3'd6
    } state_e;

    // One actuation request line per mechanism, at most one set at a time.
    typedef struct packed {
        logic vend_twenty;
        logic vend_fifty;
        logic eject10;
        logic eject20;
    } req_t;

    // Change amount expressed in units of ten dollars.
    function automatic logic [REM_W-1:0] change_tens(input logic [CHG_W-1:0] code);
        logic [REM_W-1:0] tens;
        tens = REM_W'(0);
        case (change_e'(code))
            TEN_BACK:    tens = REM_W'(1);
            THIRTY_BACK: tens = REM_W'(3);
            FORTY_BACK:  tens = REM_W'(4);
            default:     tens = REM_W'(0);
        endcase
        return tens;
    endfunction

endpackage

// File: rtl/coin_store.sv
// Level counter for one coin store: reload on refill, decrement per ejected coin.
module coin_store #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned INIT  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] level,
    output logic             empty
);

    logic [CNT_W-1:0] level_d;

    // Reload wins over a same-cycle decrement; an empty store never wraps.
    always_comb begin
        level_d = level;
        if (load) begin
            level_d = CNT_W'(INIT);
        end else if (dec && !empty) begin
            level_d = level - CNT_W'(1);
        end
    end

    // Level and its empty flag are registered together so they always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= CNT_W'(INIT);
            empty <= (INIT == 0);
        end else begin
            level <= level_d;
            empty <= (level_d == '0);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Vending back end: item chute and coin ejector handshakes with greedy change payout.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned INIT_COIN10    = 16,
    parameter int unsigned INIT_COIN20    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ITEM_W-1:0] item,
    input  logic [CHG_W-1:0]  change,
    input  logic              mech_ack,
    input  logic              refill10,
    input  logic              refill20,
    input  logic              fault_clr,
    output logic              busy,
    output logic              vend_twenty,
    output logic              vend_fifty,
    output logic              eject10,
    output logic              eject20,
    output logic [CNT_W-1:0]  coin10_level,
    output logic [CNT_W-1:0]  coin20_level,
    output logic [1:0]        fault
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    fault_e           fault_q, fault_d;
    logic             fifty_q, fifty_d;
    logic             use20_q, use20_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             busy_d;
    req_t             req_d;
    logic             dec10_c, dec20_c;
    logic             empty10, empty20;

    coin_store #(
        .CNT_W (CNT_W),
        .INIT  (INIT_COIN10)
    ) u_store10 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (refill10),
        .dec   (dec10_c),
        .level (coin10_level),
        .empty (empty10)
    );

    coin_store #(
        .CNT_W (CNT_W),
        .INIT  (INIT_COIN20)
    ) u_store20 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (refill20),
        .dec   (dec20_c),
        .level (coin20_level),
        .empty (empty20)
    );

    // Next state, transaction context, store decrements and next registered outputs.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        fifty_d = fifty_q;
        use20_d = use20_q;
        rem_d   = rem_q;
        dec10_c = 1'b0;
        dec20_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (item == ITEM_TWENTY || item == ITEM_FIFTY) begin
                    state_d = ST_ITEM_REQ;
                    fifty_d = (item == ITEM_FIFTY);
                    rem_d   = change_tens(change);
                end
            end
            ST_ITEM_REQ: begin
                if (mech_ack) begin
                    state_d = ST_ITEM_REL;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_ITEM_REL: begin
                if (!mech_ack) begin
                    state_d = ST_COIN_SEL;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_COIN_SEL: begin
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else if (rem_q >= REM_W'(2) && !empty20) begin
                    state_d = ST_COIN_REQ;
                    use20_d = 1'b1;
                end else if (!empty10) begin
                    state_d = ST_COIN_REQ;
                    use20_d = 1'b0;
                end else begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_SHORT;
                end
            end
            ST_COIN_REQ: begin
                if (mech_ack) begin
                    state_d = ST_COIN_REL;
                    if (use20_q) begin
                        dec20_c = 1'b1;
                        rem_d   = rem_q - REM_W'(2);
                    end else begin
                        dec10_c = 1'b1;
                        rem_d   = rem_q - REM_W'(1);
                    end
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_COIN_REL: begin
                if (!mech_ack) begin
                    state_d = ST_COIN_SEL;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_IDLE;
                    fault_d = FAULT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fault_d = FAULT_NONE;
            end
        endcase

        // Handshake timer restarts on every state entry and only runs while waiting on mech_ack.
        tmr_d = '0;
        if (state_d == state_q &&
            (state_q == ST_ITEM_REQ || state_q == ST_ITEM_REL ||
             state_q == ST_COIN_REQ || state_q == ST_COIN_REL)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        busy_d = (state_d != ST_IDLE);
        req_d  = '0;
        if (state_d == ST_ITEM_REQ) begin
            req_d.vend_twenty = !fifty_d;
            req_d.vend_fifty  = fifty_d;
        end
        if (state_d == ST_COIN_REQ) begin
            req_d.eject20 = use20_d;
            req_d.eject10 = !use20_d;
        end
    end

    // State, transaction context and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fault_q     <= FAULT_NONE;
            fifty_q     <= 1'b0;
            use20_q     <= 1'b0;
            rem_q       <= '0;
            tmr_q       <= '0;
            busy        <= 1'b0;
            vend_twenty <= 1'b0;
            vend_fifty  <= 1'b0;
            eject10     <= 1'b0;
            eject20     <= 1'b0;
            fault       <= 2'd0;
        end else begin
            state_q     <= state_d;
            fault_q     <= fault_d;
            fifty_q     <= fifty_d;
            use20_q     <= use20_d;
            rem_q       <= rem_d;
            tmr_q       <= tmr_d;
            busy        <= busy_d;
            vend_twenty <= req_d.vend_twenty;
            vend_fifty  <= req_d.vend_fifty;
            eject10     <= req_d.eject10;
            eject20     <= req_d.eject20;
            fault       <= fault_d;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized transactions vs a payout model.
module tb_change_dispenser;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned INIT10 = 6;
    localparam int unsigned INIT20 = 3;
    localparam int unsigned TMO    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       item = 2'd0;
    logic [1:0]       change = 2'd0;
    logic             mech_ack = 1'b0;
    logic             refill10 = 1'b0;
    logic             refill20 = 1'b0;
    logic             fault_clr = 1'b0;
    logic             busy;
    logic             vend_twenty;
    logic             vend_fifty;
    logic             eject10;
    logic             eject20;
    logic [CNT_W-1:0] coin10_level;
    logic [CNT_W-1:0] coin20_level;
    logic [1:0]       fault;

    int vectors = 0;
    int miscompares = 0;
    int m10;
    int m20;

    always #5 clk = ~clk;

    change_dispenser #(
        .CNT_W          (CNT_W),
        .INIT_COIN10    (INIT10),
        .INIT_COIN20    (INIT20),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .item         (item),
        .change       (change),
        .mech_ack     (mech_ack),
        .refill10     (refill10),
        .refill20     (refill20),
        .fault_clr    (fault_clr),
        .busy         (busy),
        .vend_twenty  (vend_twenty),
        .vend_fifty   (vend_fifty),
        .eject10      (eject10),
        .eject20      (eject20),
        .coin10_level (coin10_level),
        .coin20_level (coin20_level),
        .fault        (fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({busy, vend_twenty, vend_fifty, eject10, eject20} !== 5'b0) begin
            $display("FAIL reset_outputs got %b want 00000", {busy, vend_twenty, vend_fifty, eject10, eject20});
            miscompares++;
        end
        vectors++;
        if (fault !== 2'd0) begin
            $display("FAIL reset_fault got %0d want 0", fault);
            miscompares++;
        end
        vectors++;
        if (coin10_level !== CNT_W'(INIT10) || coin20_level !== CNT_W'(INIT20)) begin
            $display("FAIL reset_levels got %0d/%0d want %0d/%0d", coin10_level, coin20_level, INIT10, INIT20);
            miscompares++;
        end
        rst_n = 1'b1;
        tick();
        m10 = INIT10;
        m20 = INIT20;
    endtask

    task automatic refill_idle(input bit r10, input bit r20);
        refill10 = r10;
        refill20 = r20;
        tick();
        refill10 = 1'b0;
        refill20 = 1'b0;
        if (r10) m10 = INIT10;
        if (r20) m20 = INIT20;
        vectors++;
        if (coin10_level !== CNT_W'(m10) || coin20_level !== CNT_W'(m20)) begin
            $display("FAIL refill_levels got %0d/%0d want %0d/%0d", coin10_level, coin20_level, m10, m20);
            miscompares++;
        end
    endtask

    // One full transaction with a responsive mechanism; codes 1=vend20 2=vend50 3=eject10 4=eject20.
    task automatic run_txn(input int it, input int ch, input int ack_dly, input int rel_dly,
                           input bit refill_on_20, input bit scramble);
        int exp_q[$];
        int obs_q[$];
        int e10, e20, rem, exp_fault;
        int mst, cnt, cyc, drop_cyc;
        bit done, fired, hung;
        logic [3:0] req;

        e10 = m10;
        e20 = m20;
        rem = (ch == 1) ? 1 : (ch == 2) ? 3 : (ch == 3) ? 4 : 0;
        exp_fault = 0;
        exp_q.push_back((it == 1) ? 1 : 2);
        while (rem > 0) begin
            if (rem >= 2 && e20 > 0) begin
                exp_q.push_back(4); e20--; rem -= 2;
            end else if (e10 > 0) begin
                exp_q.push_back(3); e10--; rem -= 1;
            end else begin
                exp_fault = 2;
                break;
            end
        end

        item = 2'(it);
        change = 2'(ch);
        tick();
        vectors++;
        if (busy !== 1'b1 || vend_twenty !== (it == 1) || vend_fifty !== (it == 2)) begin
            $display("FAIL start_latency got busy=%b v20=%b v50=%b want busy=1 item=%0d", busy, vend_twenty, vend_fifty, it);
            miscompares++;
        end
        item = 2'd0;
        change = 2'd0;

        mst = 0; cnt = 0; cyc = 0; drop_cyc = -100;
        done = 1'b0; fired = 1'b0; hung = 1'b0;
        while (!done) begin
            req = {vend_twenty, vend_fifty, eject10, eject20};
            refill20 = 1'b0;
            vectors++;
            if ($countones(req) > 1) begin
                $display("FAIL onehot got %b want at most one request", req);
                miscompares++;
            end
            if (busy !== 1'b1 || fault !== 2'd0) begin
                done = 1'b1;
            end else begin
                if (mst == 0 && req != 4'b0) begin
                    obs_q.push_back(req == 4'b1000 ? 1 : req == 4'b0100 ? 2 : req == 4'b0010 ? 3 : 4);
                    cnt = 0;
                    mst = 1;
                end
                if (mst == 1) begin
                    cnt++;
                    if (cnt >= ack_dly) begin
                        mech_ack = 1'b1;
                        if (refill_on_20 && !fired && req == 4'b0001) begin
                            refill20 = 1'b1;
                            fired = 1'b1;
                        end
                        mst = 2;
                    end
                end
                if (mst == 2 && req == 4'b0) begin
                    cnt = 0;
                    mst = 3;
                end
                if (mst == 3) begin
                    cnt++;
                    if (cnt >= rel_dly) begin
                        mech_ack = 1'b0;
                        drop_cyc = cyc;
                        mst = 0;
                    end
                end
                if (scramble) begin
                    item = 2'($urandom_range(3));
                    change = 2'($urandom_range(3));
                end
                tick();
                cyc++;
                if (cyc > 300) begin
                    $display("FAIL txn_budget got busy=%b after %0d cycles want completion", busy, cyc);
                    miscompares++;
                    hung = 1'b1;
                    done = 1'b1;
                end
            end
        end
        item = 2'd0;
        change = 2'd0;
        mech_ack = 1'b0;
        refill20 = 1'b0;

        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL seq_len got %0d want %0d", obs_q.size(), exp_q.size());
            miscompares++;
        end else begin
            foreach (exp_q[i]) begin
                vectors++;
                if (obs_q[i] != exp_q[i]) begin
                    $display("FAIL seq[%0d] got code %0d want %0d", i, obs_q[i], exp_q[i]);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (fault !== 2'(exp_fault)) begin
            $display("FAIL txn_fault got %0d want %0d", fault, exp_fault);
            miscompares++;
        end
        if (!hung) begin
            vectors++;
            if (cyc - drop_cyc != 2) begin
                $display("FAIL end_timing got %0d cycles after release want 2", cyc - drop_cyc);
                miscompares++;
            end
        end
        if (exp_fault == 2) begin
            vectors++;
            if (busy !== 1'b1 || {vend_twenty, vend_fifty, eject10, eject20} !== 4'b0) begin
                $display("FAIL short_hold got busy=%b req=%b want busy=1 req=0000", busy, {vend_twenty, vend_fifty, eject10, eject20});
                miscompares++;
            end
            fault_clr = 1'b1;
            tick();
            fault_clr = 1'b0;
            vectors++;
            if (busy !== 1'b0 || fault !== 2'd0) begin
                $display("FAIL short_clear got busy=%b fault=%0d want 0/0", busy, fault);
                miscompares++;
            end
        end

        m10 = e10;
        m20 = fired ? INIT20 : e20;
        vectors++;
        if (coin10_level !== CNT_W'(m10) || coin20_level !== CNT_W'(m20)) begin
            $display("FAIL txn_levels got %0d/%0d want %0d/%0d", coin10_level, coin20_level, m10, m20);
            miscompares++;
        end
    endtask

    task automatic test_ignore();
        for (int i = 0; i < 10; i++) begin
            item = ($urandom_range(1) == 0) ? 2'd0 : 2'd3;
            change = 2'($urandom_range(3));
            tick();
            vectors++;
            if (busy !== 1'b0 || {vend_twenty, vend_fifty} !== 2'b0) begin
                $display("FAIL ignore_item got busy=%b vend=%b want idle", busy, {vend_twenty, vend_fifty});
                miscompares++;
            end
        end
        item = 2'd0;
        change = 2'd0;
    endtask

    task automatic test_timeout();
        item = 2'd1;
        change = 2'd0;
        tick();
        item = 2'd0;
        for (int k = 1; k < int'(TMO); k++) begin
            tick();
            vectors++;
            if (vend_twenty !== 1'b1 || fault !== 2'd0) begin
                $display("FAIL timeout_hold cycle %0d got vend=%b fault=%0d want 1/0", k, vend_twenty, fault);
                miscompares++;
            end
        end
        tick();
        vectors++;
        if (vend_twenty !== 1'b0 || fault !== 2'd1 || busy !== 1'b1) begin
            $display("FAIL timeout_fire got vend=%b fault=%0d busy=%b want 0/1/1", vend_twenty, fault, busy);
            miscompares++;
        end
        for (int k = 0; k < 4; k++) begin
            item = 2'(1 + (k % 2));
            change = 2'($urandom_range(3));
            tick();
            vectors++;
            if ({vend_twenty, vend_fifty, eject10, eject20} !== 4'b0 || fault !== 2'd1 || busy !== 1'b1) begin
                $display("FAIL fault_ignore got req=%b fault=%0d busy=%b want 0000/1/1",
                         {vend_twenty, vend_fifty, eject10, eject20}, fault, busy);
                miscompares++;
            end
        end
        item = 2'd0;
        change = 2'd0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        vectors++;
        if (busy !== 1'b0 || fault !== 2'd0) begin
            $display("FAIL timeout_clear got busy=%b fault=%0d want 0/0", busy, fault);
            miscompares++;
        end
        vectors++;
        if (coin10_level !== CNT_W'(m10) || coin20_level !== CNT_W'(m20)) begin
            $display("FAIL timeout_levels got %0d/%0d want %0d/%0d", coin10_level, coin20_level, m10, m20);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        refill_idle(1'b1, 1'b1);
        run_txn(2, 2, 1, 1, 1'b0, 1'b0);
        item = 2'd1;
        change = 2'd3;
        tick();
        item = 2'd0;
        change = 2'd0;
        mech_ack = 1'b1;
        tick();
        mech_ack = 1'b0;
        tick();
        tick();
        vectors++;
        if (eject20 !== 1'b1) begin
            $display("FAIL mid_setup got eject20=%b want 1", eject20);
            miscompares++;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, vend_twenty, vend_fifty, eject10, eject20} !== 5'b0 || fault !== 2'd0) begin
            $display("FAIL mid_reset_out got %b fault=%0d want 00000/0",
                     {busy, vend_twenty, vend_fifty, eject10, eject20}, fault);
            miscompares++;
        end
        vectors++;
        if (coin10_level !== CNT_W'(INIT10) || coin20_level !== CNT_W'(INIT20)) begin
            $display("FAIL mid_reset_levels got %0d/%0d want %0d/%0d", coin10_level, coin20_level, INIT10, INIT20);
            miscompares++;
        end
        #2 rst_n = 1'b1;
        m10 = INIT10;
        m20 = INIT20;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL post_reset_busy got %b want 0", busy);
            miscompares++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(5) == 0) refill_idle(1'b1, 1'b0);
            if ($urandom_range(5) == 0) refill_idle(1'b0, 1'b1);
            run_txn(int'($urandom_range(1, 2)), int'($urandom_range(3)),
                    int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), 1'b0, 1'b1);
            tick();
        end
    endtask

    initial begin
        test_reset();
        run_txn(1, 0, 3, 2, 1'b0, 1'b0);
        run_txn(1, 3, 2, 1, 1'b0, 1'b0);
        run_txn(2, 3, 1, 2, 1'b0, 1'b0);
        test_ignore();
        test_timeout();
        refill_idle(1'b1, 1'b1);
        run_txn(1, 2, 2, 2, 1'b1, 1'b0);
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion want finish before time limit");
        $fatal(1);
    end

endmodule
